// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg: shared FSM state, default widths and response record for the ap_ctrl initiator.
package ap_ctrl_pkg;
   typedef enum logic [1:0] {CRST, IDLE, RUN, RESP} state_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;
   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic                  err;
      logic [DEF_CNT_W-1:0]  cycles;
   } rsp_t;
endpackage

// File: rtl/ap_ctrl_sat_counter.sv
// ap_ctrl_sat_counter: clear/enable counter that saturates at all-ones, or wraps when WRAP=1.
module ap_ctrl_sat_counter
   import ap_ctrl_pkg::*;
#(
   parameter int W    = DEF_CNT_W,
   parameter bit WRAP = 1'b0
) (
   input  logic         ap_clk,
   input  logic         ap_rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : (en && (WRAP || cnt_q != '1)) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   assign q = cnt_q;
endmodule

// File: rtl/ap_ctrl_master.sv
// ap_ctrl_master: resets the core, starts one job per request, returns ap_return or a timeout error.
// Define AP_CTRL_MASTER_STATS_EN to add the stat_jobs/stat_timeouts completion counters.
module ap_ctrl_master
   import ap_ctrl_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int RST_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  rsp_cycles,
   output logic              core_rst_n,
   output logic [DATA_W-1:0] core_a,
   output logic [DATA_W-1:0] core_b,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_return
`ifdef AP_CTRL_MASTER_STATS_EN
   ,
   output logic [31:0]       stat_jobs,
   output logic [31:0]       stat_timeouts
`endif
);
   state_t              state_q, state_d;
   logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d, core_start_q, core_start_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d, core_a_q, core_a_d, core_b_q, core_b_d;
   logic [CNT_W-1:0]    rsp_cycles_q, rsp_cycles_d, rst_cnt, run_cnt;
   logic                accept, rsp_hs, run_done, run_tmo;

   assign accept   = state_q == IDLE && req_valid && req_ready_q;
   assign rsp_hs   = rsp_valid_q && rsp_ready;
   // done has priority over timeout; a sticky done outside RUN is never looked at
   assign run_done = state_q == RUN && core_done;
   assign run_tmo  = state_q == RUN && !core_done && run_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

   ap_ctrl_sat_counter #(.W(CNT_W)) u_rst_cnt (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(state_q != CRST), .en(state_q == CRST), .q(rst_cnt)
   );
   ap_ctrl_sat_counter #(.W(CNT_W)) u_run_cnt (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(accept), .en(state_q == RUN), .q(run_cnt)
   );

   always_comb begin
      state_d      = state_q;
      state_d      = (state_q == CRST && rst_cnt == CNT_W'(RST_CYCLES - 1)) ? IDLE :
                     accept ? RUN : (run_done || run_tmo) ? RESP : rsp_hs ? CRST : state_q;
      req_ready_d  = state_d == IDLE;
      rsp_valid_d  = state_d == RESP;
      core_start_d = state_d == RUN;
      core_a_d     = accept ? req_a : core_a_q;
      core_b_d     = accept ? req_b : core_b_q;
      rsp_data_d   = run_done ? core_return : run_tmo ? '0 : rsp_data_q;
      rsp_err_d    = run_done ? 1'b0 : run_tmo ? 1'b1 : rsp_err_q;
      rsp_cycles_d = run_done ? run_cnt : run_tmo ? CNT_W'(TIMEOUT_CYCLES) : rsp_cycles_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         state_q      <= CRST;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         core_start_q <= 1'b0;
         rsp_data_q   <= '0;
         core_a_q     <= '0;
         core_b_q     <= '0;
         rsp_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         core_start_q <= core_start_d;
         rsp_data_q   <= rsp_data_d;
         core_a_q     <= core_a_d;
         core_b_q     <= core_b_d;
         rsp_cycles_q <= rsp_cycles_d;
      end

   // core reset follows ap_rst_n combinationally so the core is held during system reset
   assign core_rst_n = ap_rst_n && state_q != CRST;
   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_cycles = rsp_cycles_q;
   assign core_a     = core_a_q;
   assign core_b     = core_b_q;
   assign core_start = core_start_q;

`ifdef AP_CTRL_MASTER_STATS_EN
   ap_ctrl_sat_counter #(.W(32), .WRAP(1'b1)) u_stat_jobs (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(1'b0), .en(rsp_hs && !rsp_err_q), .q(stat_jobs)
   );
   ap_ctrl_sat_counter #(.W(32), .WRAP(1'b1)) u_stat_timeouts (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(1'b0), .en(rsp_hs && rsp_err_q), .q(stat_timeouts)
   );
`endif
endmodule

// File: tb/tb_ap_ctrl_master.sv
// tb_ap_ctrl_master: drives ap_ctrl_master against a behavioural GCD core with random jobs and latencies.
module tb_ap_ctrl_master;
   localparam int DW = 32, CW = 16, RC = 4, TO = 64;

   logic          ap_clk = 1'b0, ap_rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
   logic [DW-1:0] req_a = '0, req_b = '0;
   logic          req_ready, rsp_valid, rsp_err, core_rst_n, core_start, core_done;
   logic [DW-1:0] rsp_data, core_a, core_b, core_return;
   logic [CW-1:0] rsp_cycles;
`ifdef AP_CTRL_MASTER_STATS_EN
   logic [31:0]   stat_jobs, stat_timeouts;
`endif

   int checks = 0, errors = 0;
   int exp_jobs = 0, exp_tmo = 0;

   int            lat = 1, k = 0;
   bit            stub = 1'b0, force_done = 1'b0;
   logic          cdone = 1'b0;
   logic [DW-1:0] cret = '0;

   logic [DW-1:0] j_data;
   logic          j_err;
   logic [CW-1:0] j_cyc;
   int            j_edges, j_crst;
   bit            j_start_ok, j_rdy_busy, j_early, j_stable, j_post;

   ap_ctrl_master #(.DATA_W(DW), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_cycles(rsp_cycles), .core_rst_n(core_rst_n), .core_a(core_a), .core_b(core_b),
      .core_start(core_start), .core_done(core_done), .core_return(core_return)
`ifdef AP_CTRL_MASTER_STATS_EN
      , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic [DW-1:0] t;
      while (y != 0) begin t = x % y; x = y; y = t; end
      return x;
   endfunction

   // partner core: done (sticky until reset) 'lat' cycles after it first sees ap_start
   always @(posedge ap_clk or negedge core_rst_n)
      if (!core_rst_n) begin
         k <= 0; cdone <= 1'b0; cret <= '0;
      end else if (core_start && !cdone && !stub) begin
         k <= k + 1;
         if (k + 1 == lat) begin cdone <= 1'b1; cret <= ref_gcd(core_a, core_b); end
      end
   assign core_done   = cdone | force_done;
   assign core_return = cret;

   // one full job from the IDLE negedge until the next IDLE negedge; results land in j_*
   task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] b, input int l, input bit s,
                          input bit hold, input int bp);
      int n;
      lat = l; stub = s; req_a = a; req_b = b; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge ap_clk); n++; end
      @(negedge ap_clk);
      j_start_ok = core_start === 1'b1 && core_a === a && core_b === b && req_ready === 1'b0;
      if (!hold) req_valid = 1'b0;
      j_edges = 0; j_rdy_busy = 1'b0; j_early = 1'b0;
      while (rsp_valid !== 1'b1 && j_edges < TO + 10) begin
         if (req_ready !== 1'b0) j_rdy_busy = 1'b1;
         if (core_done !== 1'b0 && j_edges < l) j_early = 1'b1;
         @(negedge ap_clk); j_edges++;
      end
      j_data = rsp_data; j_err = rsp_err; j_cyc = rsp_cycles; j_stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1;
         @(negedge ap_clk);
         if (rsp_valid !== 1'b1 || rsp_data !== j_data || rsp_err !== j_err || rsp_cycles !== j_cyc ||
             req_ready !== 1'b0) j_stable = 1'b0;
      end
      req_valid = hold;
      rsp_ready = 1'b1; @(negedge ap_clk); rsp_ready = 1'b0;
      j_post = rsp_valid === 1'b0 && core_rst_n === 1'b0 && core_start === 1'b0;
      j_crst = 0; n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         if (core_rst_n === 1'b0) j_crst++;
         @(negedge ap_clk); n++;
      end
      if (s) exp_tmo++; else exp_jobs++;
   endtask

   task automatic test_reset();
      int n, low;
      repeat (3) @(negedge ap_clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, core_start, core_rst_n} !== 5'b0 || rsp_data !== '0 ||
          rsp_cycles !== '0 || core_a !== '0 || core_b !== '0) begin
         errors++;
         $display("FAIL reset_values got rdy=%b vld=%b err=%b start=%b crst_n=%b data=%0d cyc=%0d a=%0d b=%0d exp all 0",
                  req_ready, rsp_valid, rsp_err, core_start, core_rst_n, rsp_data, rsp_cycles, core_a, core_b);
      end
      ap_rst_n = 1'b1;
      n = 0; low = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         if (core_rst_n === 1'b0) low++;
         @(negedge ap_clk); n++;
      end
      checks++;
      if (low != RC || core_rst_n !== 1'b1) begin
         errors++; $display("FAIL reset_core_hold got low=%0d crst_n=%b exp low=%0d crst_n=1", low, core_rst_n, RC);
      end
   endtask

   task automatic test_gcd();
      int l = $urandom_range(3, 12);
      run_job(32'd48, 32'd18, l, 1'b0, 1'b0, 0);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd6, 1'b0, CW'(l)}) begin
         errors++; $display("FAIL gcd_result got data=%0d err=%b cyc=%0d exp data=6 err=0 cyc=%0d", j_data, j_err, j_cyc, l);
      end
      checks++;
      if (j_edges != l + 1) begin errors++; $display("FAIL gcd_latency got %0d exp %0d", j_edges, l + 1); end
      checks++;
      if ({j_start_ok, j_rdy_busy, j_early, j_post} !== 4'b1001 || j_crst != RC) begin
         errors++;
         $display("FAIL gcd_handshake got start_ok=%b rdy_busy=%b early=%b post=%b crst=%0d exp 1 0 0 1 %0d",
                  j_start_ok, j_rdy_busy, j_early, j_post, j_crst, RC);
      end
   endtask

   task automatic test_timeout();
      run_job(32'd9, 32'd6, 1000, 1'b1, 1'b0, 0);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd0, 1'b1, CW'(TO)}) begin
         errors++; $display("FAIL timeout_result got data=%0d err=%b cyc=%0d exp data=0 err=1 cyc=%0d", j_data, j_err, j_cyc, TO);
      end
      checks++;
      if (j_edges != TO || j_crst != RC) begin
         errors++; $display("FAIL timeout_latency got edges=%0d crst=%0d exp %0d %0d", j_edges, j_crst, TO, RC);
      end
   endtask

   task automatic test_back_to_back();
      int l1 = $urandom_range(1, 10), l2 = $urandom_range(1, 10);
      run_job(32'd35, 32'd21, l1, 1'b0, 1'b1, 0);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd7, 1'b0, CW'(l1)} || j_rdy_busy || j_crst != RC) begin
         errors++; $display("FAIL b2b_first got data=%0d cyc=%0d rdy_busy=%b crst=%0d exp 7 %0d 0 %0d", j_data, j_cyc, j_rdy_busy, j_crst, l1, RC);
      end
      run_job(32'd17, 32'd5, l2, 1'b0, 1'b0, 0);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd1, 1'b0, CW'(l2)} || j_early || !j_start_ok) begin
         errors++; $display("FAIL b2b_second got data=%0d cyc=%0d early=%b start_ok=%b exp 1 %0d 0 1", j_data, j_cyc, j_early, j_start_ok, l2);
      end
   endtask

   task automatic test_backpressure();
      int l = $urandom_range(2, 9);
      run_job(32'd60, 32'd45, l, 1'b0, 1'b0, 10);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd15, 1'b0, CW'(l)}) begin
         errors++; $display("FAIL bp_result got data=%0d err=%b cyc=%0d exp 15 0 %0d", j_data, j_err, j_cyc, l);
      end
      checks++;
      if ({j_stable, j_post} !== 2'b11) begin
         errors++; $display("FAIL bp_hold got stable=%b post=%b exp 1 1", j_stable, j_post);
      end
   endtask

   task automatic test_rst_mid_run();
      int n;
      bit seen = 1'b0, started;
      lat = 30; stub = 1'b0; req_a = 32'd99; req_b = 32'd33; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge ap_clk); n++; end
      @(negedge ap_clk); req_valid = 1'b0;
      repeat (5) @(negedge ap_clk);
      started = core_start;
      ap_rst_n = 1'b0; #1;
      checks++;
      if ({started, core_rst_n, core_start, rsp_valid} !== 4'b1000) begin
         errors++; $display("FAIL mid_run_reset got start_before=%b crst_n=%b start=%b vld=%b exp 1 0 0 0", started, core_rst_n, core_start, rsp_valid);
      end
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         @(negedge ap_clk);
      end
      checks++;
      if (seen) begin errors++; $display("FAIL mid_run_no_rsp got rsp_valid=1 exp 0"); end
      run_job(32'd100, 32'd75, 6, 1'b0, 1'b0, 0);
      checks++;
      if ({j_data, j_err, j_cyc} !== {32'd25, 1'b0, CW'(6)}) begin
         errors++; $display("FAIL after_reset_job got data=%0d err=%b cyc=%0d exp 25 0 6", j_data, j_err, j_cyc);
      end
   endtask

   task automatic test_stale_done();
      bit bad = 1'b0;
      force_done = 1'b1;
      repeat (3) begin
         @(negedge ap_clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
      end
      force_done = 1'b0;
      checks++;
      if (bad) begin errors++; $display("FAIL stale_done_idle got rsp_valid=%b req_ready=%b exp 0 1", rsp_valid, req_ready); end
      run_job(32'd21, 32'd14, 8, 1'b0, 1'b0, 0);
      checks++;
      if ({j_data, j_cyc} !== {32'd7, CW'(8)}) begin
         errors++; $display("FAIL stale_done_job got data=%0d cyc=%0d exp 7 8", j_data, j_cyc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         logic [DW-1:0] a = $urandom_range(1, 5000), b = $urandom_range(1, 5000), ed;
         bit s = $urandom_range(0, 4) == 0;
         int l = $urandom_range(1, 40), bp = $urandom_range(0, 3);
         logic ee;
         logic [CW-1:0] ec;
         ed = s ? '0 : ref_gcd(a, b); ee = s; ec = s ? CW'(TO) : CW'(l);
         run_job(a, b, l, s, 1'b0, bp);
         checks++;
         if ({j_data, j_err, j_cyc} !== {ed, ee, ec} || j_edges != (s ? TO : l + 1)) begin
            errors++;
            $display("FAIL random_job%0d a=%0d b=%0d got data=%0d err=%b cyc=%0d edges=%0d exp %0d %b %0d %0d",
                     i, a, b, j_data, j_err, j_cyc, j_edges, ed, ee, ec, s ? TO : l + 1);
         end
         checks++;
         if ({j_start_ok, j_rdy_busy, j_early, j_stable, j_post} !== 5'b10011 || j_crst != RC) begin
            errors++;
            $display("FAIL random_proto%0d got start_ok=%b rdy_busy=%b early=%b stable=%b post=%b crst=%0d exp 1 0 0 1 1 %0d",
                     i, j_start_ok, j_rdy_busy, j_early, j_stable, j_post, j_crst, RC);
         end
      end
   endtask

`ifdef AP_CTRL_MASTER_STATS_EN
   task automatic test_stats();
      checks++;
      if (stat_jobs !== 32'(exp_jobs) || stat_timeouts !== 32'(exp_tmo)) begin
         errors++; $display("FAIL stats got jobs=%0d timeouts=%0d exp %0d %0d", stat_jobs, stat_timeouts, exp_jobs, exp_tmo);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_gcd();
      test_timeout();
      test_back_to_back();
      test_backpressure();
      test_stale_done();
      test_random();
`ifdef AP_CTRL_MASTER_STATS_EN
      test_stats();
`endif
      test_rst_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
